// File: rtl/mem_access_unit.sv
// Turns word/half/byte loads and stores into word accesses on a req/ack bus.
// Sub-word stores use read-modify-write. The pipeline is stalled until the access finishes.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [2:0] MODE_W  = 3'd0;
  localparam logic [2:0] MODE_HS = 3'd1;
  localparam logic [2:0] MODE_HU = 3'd2;
  localparam logic [2:0] MODE_BS = 3'd3;
  localparam logic [2:0] MODE_BU = 3'd4;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [2:0]        mode_q, mode_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic       req;
  logic [2:0] mode_n;
  logic       is_half, is_byte, mis;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                               input logic [2:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (m)
      MODE_HS: r = {{16{h[15]}}, h};
      MODE_HU: r = {16'h0000, h};
      MODE_BS: r = {{24{b[7]}}, b};
      MODE_BU: r = {24'h000000, b};
      default: r = w;
    endcase
    load_extract = r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                              input logic [1:0] a, input logic [2:0] m);
    logic [31:0] r;
    r = w;
    if (m == MODE_HS || m == MODE_HU) begin
      if (a[1]) r[31:16] = d;
      else      r[15:0]  = d;
    end else begin
      case (a)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    store_merge = r;
  endfunction

  always_comb begin
    req     = memread | memwrite;
    mode_n  = (mode > MODE_BU) ? MODE_W : mode;
    is_half = (mode_n == MODE_HS) || (mode_n == MODE_HU);
    is_byte = (mode_n == MODE_BS) || (mode_n == MODE_BU);
    mis     = ((mode_n == MODE_W) && (addr[1:0] != 2'b00)) || (is_half && addr[0]);

    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mode_d      = mode_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata[15:0];
          mode_d  = mode_n;
          err_d   = mis;
          // memwrite takes priority when both strobes are high
          if (mis) begin
            state_d = DONE;
            if (!memwrite) rdata_d = 32'h0;
          end else if (!memwrite) begin
            state_d = RD;
          end else if (is_half || is_byte) begin
            state_d = RMW_RD;
          end else begin
            state_d     = WR;
            mem_wdata_d = wdata;
          end
        end
      end
      RD: begin
        if (mem_ack) begin
          rdata_d = load_extract(mem_rdata, addr_q[1:0], mode_q);
          state_d = DONE;
        end
      end
      RMW_RD: begin
        if (mem_ack) begin
          mem_wdata_d = store_merge(mem_rdata, wdata_q, addr_q[1:0], mode_q);
          state_d     = RMW_WR;
        end
      end
      RMW_WR, WR: begin
        if (mem_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus strobes are registered from the next state so they line up with it.
    mem_req_d = (state_d == RD) || (state_d == RMW_RD) || (state_d == RMW_WR) || (state_d == WR);
    mem_we_d  = (state_d == RMW_WR) || (state_d == WR);

    stall = ((state_q == IDLE) && req) || (state_q == RD) || (state_q == RMW_RD) ||
            (state_q == RMW_WR) || (state_q == WR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mode_q      <= MODE_W;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign misalign  = (state_q == DONE) && err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory side consumer of the control decoder's memread/memwrite/mode outputs.
- Converts word/half/byte loads and stores into word-wide accesses on a req/ack memory bus.
- Performs read-modify-write for sub-word stores, and lane extraction plus sign/zero extension for loads.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, width of the CPU address and the memory bus address.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- memread  in  1  load request from control; held stable while stall=1
- memwrite  in  1  store request from control; held stable while stall=1
- mode  in  3  access size: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; stores use 0/1/3
- addr  in  ADDR_W  byte address from ALU
- wdata  in  32  store data (rt value)
- rdata  out  32  extended load result; registered
- stall  out  1  pipeline hold request
- misalign  out  1  one-cycle pulse: access rejected as misaligned
- mem_req  out  1  bus request; registered
- mem_we  out  1  bus write enable; valid with mem_req
- mem_addr  out  ADDR_W  word address: addr with bits[1:0] forced to 0
- mem_wdata  out  32  bus write data
- mem_rdata  in  32  bus read data; valid when mem_ack=1
- mem_ack  in  1  single-cycle completion strobe; arrives at the earliest in the first cycle mem_req=1

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - rdata, mem_req, mem_we, mem_addr, mem_wdata, misalign all 0.
  - stall follows its combinational equation, so it is 0 in IDLE when no request is pending.
- Reset mid-access:
  - mem_req drops immediately and the access is abandoned.
  - A late mem_ack after reset release is ignored (arrives in IDLE).
- States: IDLE, RD, RMW_RD, RMW_WR, WR, DONE.
- Request handling:
  - Request = memread|memwrite.
  - If both are high, memwrite wins and the read is ignored.
  - mode 5..7 is treated as word.
- IDLE with request:
  - Capture addr, wdata, mode and the op.
  - Misalignment check: word with addr[1:0]!=0, or half with addr[0]=1.
  - Misaligned → DONE with err flag; no bus activity.
  - Load → RD.
  - Word store → WR.
  - Half/byte store → RMW_RD.
- RD / RMW_RD: mem_req=1, mem_we=0.
  - On ack in RD: register the extracted load into rdata, then → DONE.
  - On ack in RMW_RD: merge the store lane into mem_rdata, load the result into mem_wdata, then → RMW_WR.
- RMW_WR / WR: mem_req=1, mem_we=1.
  - On ack → DONE.
- DONE: mem_req=0; misalign=err flag for this one cycle; → IDLE unconditionally.
- mem_req deasserts in the cycle after ack.
- Stall equation: stall=1 in IDLE while a request is present, and in RD/RMW_RD/RMW_WR/WR; stall=0 in DONE. The pipeline therefore advances exactly once per access.
- Lanes are little-endian:
  - Byte k = bits[8k+7:8k], with k=addr[1:0].
  - Half h = bits[16h+15:16h], with h=addr[1].
  - Signed modes replicate the lane MSB into the upper bits; unsigned modes zero-fill.
- Store merge: only the addressed lane is replaced with wdata[7:0] (byte) or wdata[15:0] (half); all other bytes are preserved.
- rdata:
  - Holds its value until the next successful load.
  - Stores do not change it.
  - A misaligned load sets rdata=0.
- mem_ack outside RD/RMW_RD/RMW_WR/WR is ignored.
- Minimum latency, counted from the first request cycle to the DONE cycle:
  - load 2 clocks
  - word store 2 clocks
  - sub-word store 3 clocks
  - misaligned 1 clock
- Each cycle of ack delay adds one cycle; there is no timeout.

Test Plan:
- lw addr=0x104, ack same cycle as req, mem_rdata=0xDEADBEEF:
  - mem_addr=0x104, mem_we=0.
  - DONE on the 3rd cycle with rdata=0xDEADBEEF.
  - stall high for exactly 2 cycles.
- lb addr=0x203, mem_rdata=0x80112233 → rdata=0xFFFFFF80.
- lbu at the same address → rdata=0x00000080.
- lhu addr=0x202, mem_rdata=0x9ABC1234 → rdata=0x00009ABC.
- lh addr=0x202, same mem_rdata → rdata=0xFFFF9ABC.
- sb addr=0x301, wdata=0x000000AA, read returns 0x11223344:
  - One read, then one write with mem_wdata=0x1122AA44.
  - stall for 3 cycles; rdata unchanged.
- sh addr=0x401:
  - misalign=1 for one cycle.
  - mem_req never asserted; stall high for 1 cycle.
- lw addr=0x0 with ack delayed 3 cycles → stall extends by 3 cycles.
- Repeat sb, but drop reset to 0 while in RMW_WR:
  - mem_req=0 immediately.
  - After release: state IDLE, stall=0 with memread/memwrite low.
  - An ack pulsed in IDLE causes no bus activity.
